// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - rv32i data-memory responder with wait states and sub-word read-modify-write
//
// Purpose: word-organised storage array serving load/store requests from the
// core. Byte and halfword stores are done as read-modify-write; a programmable
// number of wait states precedes every array access.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two)
//   WAIT_CYCLES  wait cycles inserted before each array access (0..15)
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-high reset
//   dmem_req_i     request strobe (sampled only in IDLE)
//   dmem_w_i       1 = store, 0 = load
//   dmem_size_i    00 byte, 01 half, 10/11 word
//   dmem_addr_i    byte address
//   dmem_w_data_i  store data, right-justified
//   dmem_ready_o   one-cycle completion pulse
//   dmem_r_data_o  load data, right-justified, zero-extended; held between loads
//   dmem_err_o     access rejected, valid with dmem_ready_o
//
// Build option DMEM_CTRL_ERR_EN: when defined, misaligned and out-of-range
// accesses are rejected. When undefined, low address bits are forced to the
// size alignment, the index wraps modulo DEPTH and dmem_err_o stays 0.

module dmem_ctrl #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_req_i,
  input  logic        dmem_w_i,
  input  logic [1:0]  dmem_size_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_w_data_i,
  output logic        dmem_ready_o,
  output logic [31:0] dmem_r_data_o,
  output logic        dmem_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_MERGE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          w_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic [31:0]   word_q;
  logic [3:0]    cnt_q;

  logic [31:0]   req_addr;
  logic          req_err;
  logic          accept;
  logic          sub_word_q;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_data;
  logic [31:0]   merged;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  assign accept     = (state_q == S_IDLE) && dmem_req_i;
  assign sub_word_q = ~size_q[1];
  assign rd_word    = mem[idx_q];

  // Request decode: either reject bad accesses or silently align them.
  always_comb begin
    req_addr = dmem_addr_i;
    req_err  = 1'b0;
`ifdef DMEM_CTRL_ERR_EN
    case (dmem_size_i)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = dmem_addr_i[0];
      default: req_err = |dmem_addr_i[1:0];
    endcase
    // DEPTH is a power of two, so any set bit above the index is out of range.
    if (|dmem_addr_i[31:AW+2]) begin
      req_err = 1'b1;
    end
`else
    case (dmem_size_i)
      2'b00:   req_addr = dmem_addr_i;
      2'b01:   req_addr[0] = 1'b0;
      default: req_addr[1:0] = 2'b00;
    endcase
`endif
  end

`ifndef DMEM_CTRL_ERR_EN
  // Upper address bits are discarded when the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^dmem_addr_i[31:AW+2];
`endif

  // Load lane extraction; half accesses are always half-aligned here.
  always_comb begin
    rd_shift = rd_word >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {24'd0, rd_shift[7:0]};
      2'b01:   load_data = {16'd0, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Sub-word merge into the previously read word; other lanes untouched.
  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        2'd3: merged[31:24] = data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = data_q[15:0];
    end else begin
      merged[15:0] = data_q[15:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_req_i) begin
          if (req_err) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_q && sub_word_q) begin
          state_d = S_MERGE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_MERGE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / array-control logic
  always_comb begin
    dmem_ready_o = 1'b0;
    dmem_err_o   = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = data_q;
    case (state_q)
      S_ACCESS: begin
        mem_we = w_q && !sub_word_q;
      end
      S_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
      end
      S_RESP: begin
        dmem_ready_o = 1'b1;
        dmem_err_o   = err_q;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Request capture, wait counter and load-data register
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      lane_q        <= 2'b00;
      size_q        <= 2'b00;
      w_q           <= 1'b0;
      data_q        <= 32'd0;
      err_q         <= 1'b0;
      word_q        <= 32'd0;
      cnt_q         <= 4'd0;
      dmem_r_data_o <= 32'd0;
    end else begin
      if (accept) begin
        idx_q  <= req_addr[AW+1:2];
        lane_q <= req_addr[1:0];
        size_q <= dmem_size_i;
        w_q    <= dmem_w_i;
        data_q <= dmem_w_data_i;
        err_q  <= req_err;
        cnt_q  <= WAIT_INIT;
      end
      if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == S_ACCESS) begin
        word_q <= rd_word;
        if (!w_q) begin
          dmem_r_data_o <= load_data;
        end
      end
    end
  end

  // Storage array; a reset edge drops any write not yet committed.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[idx_q] <= mem_wdata;
    end
  end

endmodule
